// File: rtl/srio_nwr_packetizer.sv
// Segments a length-tagged 64-bit payload stream into SRIO NWRITE packets.
// Each packet is one HELLO header beat followed by up to MAX_BYTES of
// payload beats. The payload beats pass straight through to the ireq
// AXI-Stream port.
//
// Ports:
//   clk_srio, reset_srio      clock, asynchronous active-high reset
//   base_addr_in, length_in   frame start address and byte count,
//                             sampled when the frame starts
//   nwr_req_in, first_in      frame start markers on the first beat
//   data_in, valid_in,        upstream payload stream; keep_in is used
//   keep_in, last_in,         on the frame's final beat only
//   ready_out
//   ireq_*                    SRIO core request stream; tuser is constant
//   busy_out                  high whenever a frame is in progress
//   err_out                   one-cycle pulse on a framing or length error
module srio_nwr_packetizer #(
    parameter int unsigned MAX_BYTES = 256,
    parameter logic [15:0] SRC_ID    = 16'h0001,
    parameter logic [15:0] DEST_ID   = 16'h00FF,
    parameter logic [1:0]  PRIO      = 2'b01
) (
    input  logic        clk_srio,
    input  logic        reset_srio,
    input  logic [33:0] base_addr_in,
    input  logic        nwr_req_in,
    input  logic [15:0] length_in,
    input  logic [63:0] data_in,
    input  logic        valid_in,
    input  logic        first_in,
    input  logic [7:0]  keep_in,
    input  logic        last_in,
    output logic        ready_out,
    output logic [63:0] ireq_tdata,
    output logic        ireq_tvalid,
    output logic [7:0]  ireq_tkeep,
    output logic        ireq_tlast,
    output logic [31:0] ireq_tuser,
    input  logic        ireq_tready,
    output logic        busy_out,
    output logic        err_out
);

    localparam int unsigned BEAT_W = $clog2(MAX_BYTES / 8) + 1;
    localparam int unsigned SEG_W  = 9;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HEADER = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_DROP   = 2'd3;

    logic [1:0]        state, state_d;
    logic [15:0]       rem, rem_d;
    logic [33:0]       addr, addr_d;
    logic [7:0]        tid, tid_d;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_d;
    logic              err_q, err_d;

    logic [SEG_W-1:0]  seg_c;
    logic [BEAT_W-1:0] seg_beats_c;
    logic              pkt_end_c;
    logic              frame_end_c;
    logic              accept_c;
    logic              start_c;
    logic [15:0]       rem_after_c;
    logic [63:0]       header_c;

    // Current segment is derived from the remaining byte count, so it stays
    // valid through both the header and the data phase of a packet.
    assign seg_c       = (rem > 16'(MAX_BYTES)) ? SEG_W'(MAX_BYTES) : SEG_W'(rem);
    assign seg_beats_c = BEAT_W'((seg_c + SEG_W'(7)) >> 3);
    assign pkt_end_c   = (beat_cnt == seg_beats_c - BEAT_W'(1));
    assign frame_end_c = pkt_end_c && (rem <= 16'(MAX_BYTES));
    assign accept_c    = (state == S_DATA) && valid_in && ireq_tready;
    assign start_c     = valid_in && (first_in || nwr_req_in);
    assign rem_after_c = rem - 16'(seg_c);

    assign header_c = {tid, 4'h5, 4'h4, 1'b0, PRIO, 1'b0,
                       8'(seg_c - SEG_W'(1)), 2'b00, addr};

    assign ireq_tuser = {SRC_ID, DEST_ID};
    assign busy_out   = (state != S_IDLE);
    assign err_out    = err_q;

    // State and datapath registers
    always_ff @(posedge clk_srio or posedge reset_srio) begin
        if (reset_srio) begin
            state    <= S_IDLE;
            rem      <= '0;
            addr     <= '0;
            tid      <= '0;
            beat_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            rem      <= rem_d;
            addr     <= addr_d;
            tid      <= tid_d;
            beat_cnt <= beat_cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state and bookkeeping
    always_comb begin
        state_d    = state;
        rem_d      = rem;
        addr_d     = addr;
        tid_d      = tid;
        beat_cnt_d = beat_cnt;
        err_d      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_c) begin
                    rem_d  = length_in;
                    addr_d = base_addr_in;
                    if (length_in == 16'd0) begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (ireq_tready) begin
                    state_d    = S_DATA;
                    beat_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    beat_cnt_d = beat_cnt + BEAT_W'(1);
                    if (last_in && !frame_end_c) begin
                        // Upstream ended the frame early: close the packet here.
                        err_d   = 1'b1;
                        tid_d   = tid + 8'd1;
                        state_d = S_IDLE;
                    end else if (pkt_end_c) begin
                        rem_d  = rem_after_c;
                        addr_d = addr + 34'(MAX_BYTES);
                        tid_d  = tid + 8'd1;
                        if (frame_end_c && !last_in) begin
                            // Counted length exhausted but upstream keeps going.
                            err_d   = 1'b1;
                            state_d = S_DROP;
                        end else if (rem_after_c != 16'd0) begin
                            state_d = S_HEADER;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                if (valid_in && last_in) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // ireq outputs; DATA is a combinational pass-through of the upstream beat
    always_comb begin
        ready_out   = 1'b0;
        ireq_tvalid = 1'b0;
        ireq_tdata  = '0;
        ireq_tkeep  = '0;
        ireq_tlast  = 1'b0;
        case (state)
            S_HEADER: begin
                ireq_tvalid = 1'b1;
                ireq_tdata  = header_c;
                ireq_tkeep  = 8'hFF;
            end
            S_DATA: begin
                ready_out   = ireq_tready;
                ireq_tvalid = valid_in;
                ireq_tdata  = data_in;
                ireq_tkeep  = frame_end_c ? keep_in : 8'hFF;
                ireq_tlast  = pkt_end_c || last_in;
            end
            S_DROP: begin
                ready_out = 1'b1;
            end
            default: begin
                ready_out = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_srio_nwr_packetizer.sv
// Randomized self-checking bench for srio_nwr_packetizer. A packet-level
// model turns each driven frame into the expected ireq beat list, and a
// monitor records every accepted ireq beat for comparison.
module tb_srio_nwr_packetizer;

    localparam int MAX = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [33:0] base_addr_in = '0;
    logic        nwr_req_in = 1'b0;
    logic [15:0] length_in = '0;
    logic [63:0] data_in = '0;
    logic        valid_in = 1'b0;
    logic        first_in = 1'b0;
    logic [7:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_out;
    logic [63:0] ireq_tdata;
    logic        ireq_tvalid;
    logic [7:0]  ireq_tkeep;
    logic        ireq_tlast;
    logic [31:0] ireq_tuser;
    logic        ireq_tready;
    logic        busy_out;
    logic        err_out;

    srio_nwr_packetizer dut (
        .clk_srio     (clk),
        .reset_srio   (rst),
        .base_addr_in (base_addr_in),
        .nwr_req_in   (nwr_req_in),
        .length_in    (length_in),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .first_in     (first_in),
        .keep_in      (keep_in),
        .last_in      (last_in),
        .ready_out    (ready_out),
        .ireq_tdata   (ireq_tdata),
        .ireq_tvalid  (ireq_tvalid),
        .ireq_tkeep   (ireq_tkeep),
        .ireq_tlast   (ireq_tlast),
        .ireq_tuser   (ireq_tuser),
        .ireq_tready  (ireq_tready),
        .busy_out     (busy_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int miss = 0;
    int tready_mode = 0;   // 0: always ready, 1: toggle, 2: random

    // Expected and observed ireq beats, cumulative over the whole run
    logic [63:0] exp_d[$];
    logic [7:0]  exp_k[$];
    logic        exp_l[$];
    int          exp_err = 0;
    logic [7:0]  tid_m = 8'h00;

    logic [63:0] obs_d[$];
    logic [7:0]  obs_k[$];
    logic        obs_l[$];
    int          obs_err = 0;
    int          stab_viol = 0;
    bit          mon_en = 1'b1;

    initial begin
        ireq_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       ireq_tready = 1'b1;
                1:       ireq_tready = ~ireq_tready;
                default: ireq_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: records accepted beats, error pulses and stall stability
    bit          held = 1'b0;
    logic [63:0] hd;
    logic [7:0]  hk;
    logic        hl;
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            held = 1'b0;
        end else begin
            if (held && (ireq_tvalid !== 1'b1 || ireq_tdata !== hd ||
                         ireq_tkeep !== hk || ireq_tlast !== hl))
                stab_viol++;
            held = ireq_tvalid && !ireq_tready;
            hd = ireq_tdata;
            hk = ireq_tkeep;
            hl = ireq_tlast;
            if (ireq_tvalid && ireq_tready) begin
                obs_d.push_back(ireq_tdata);
                obs_k.push_back(ireq_tkeep);
                obs_l.push_back(ireq_tlast);
            end
            if (err_out) obs_err++;
        end
    end

    // Drive one frame, then append the model's expected beats.
    task automatic send_frame(input logic [33:0] base, input logic [15:0] len,
                              input int nbeats, input int last_at,
                              input logic [7:0] kfinal, input bit gaps,
                              output int acc_n);
        logic [63:0] d[$];
        logic [7:0]  k[$];
        int          rem;
        int          seg;
        int          sb;
        int          kx;
        bit          done;
        bit          fin;
        bit          el;
        logic [33:0] addr;
        acc_n = 0;
        for (int i = 0; i < nbeats; i++) begin
            logic [63:0] dat;
            logic [7:0]  kk;
            bit          acc;
            int          to;
            dat = {$urandom, $urandom};
            kk  = (i == nbeats - 1) ? kfinal : 8'($urandom);
            d.push_back(dat);
            k.push_back(kk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            valid_in     = 1'b1;
            data_in      = dat;
            keep_in      = kk;
            first_in     = (i == 0);
            nwr_req_in   = (i == 0);
            last_in      = (i == last_at);
            base_addr_in = base;
            length_in    = len;
            acc = 1'b0;
            to  = 0;
            while (!acc && to <= 1000) begin
                @(negedge clk);
                acc = ready_out;
                @(posedge clk);
                #1;
                if (!acc) to++;
            end
            if (!acc) begin
                vec++;
                miss++;
                $display("FAIL beat accept timeout: beat %0d of len %0d never accepted, required within 1000 cycles", i, len);
                break;
            end
            acc_n++;
        end
        valid_in   = 1'b0;
        first_in   = 1'b0;
        nwr_req_in = 1'b0;
        last_in    = 1'b0;

        if (len == 16'd0) begin
            exp_err++;
        end else begin
            rem  = int'(len);
            addr = base;
            kx   = 0;
            done = 1'b0;
            while (!done) begin
                seg = (rem > MAX) ? MAX : rem;
                sb  = (seg + 7) / 8;
                exp_d.push_back({tid_m, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'(seg - 1), 2'b00, addr});
                exp_k.push_back(8'hFF);
                exp_l.push_back(1'b0);
                for (int j = 0; j < sb && !done; j++) begin
                    fin = (rem <= MAX) && (j == sb - 1);
                    el  = (kx == last_at);
                    exp_d.push_back(d[kx]);
                    exp_k.push_back(fin ? k[kx] : 8'hFF);
                    exp_l.push_back((j == sb - 1) || el);
                    kx++;
                    if (el && !fin) begin
                        exp_err++;
                        tid_m++;
                        done = 1'b1;
                    end else if (j == sb - 1) begin
                        tid_m++;
                        addr = addr + 34'(MAX);
                        rem  = rem - seg;
                        if (fin) begin
                            if (!el) exp_err++;
                            done = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (busy_out !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            vec++;
            miss++;
            $display("FAIL drain timeout: busy_out still %b, required 0", busy_out);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tready_mode = 0;
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        tid_m = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vec++; if (ready_out !== 1'b0)   begin miss++; $display("FAIL reset ready_out: got %b expected 0", ready_out); end
        vec++; if (ireq_tvalid !== 1'b0) begin miss++; $display("FAIL reset tvalid: got %b expected 0", ireq_tvalid); end
        vec++; if (ireq_tlast !== 1'b0)  begin miss++; $display("FAIL reset tlast: got %b expected 0", ireq_tlast); end
        vec++; if (busy_out !== 1'b0)    begin miss++; $display("FAIL reset busy: got %b expected 0", busy_out); end
        vec++; if (err_out !== 1'b0)     begin miss++; $display("FAIL reset err: got %b expected 0", err_out); end
        vec++; if (ireq_tdata !== 64'h0) begin miss++; $display("FAIL reset tdata: got %h expected 0", ireq_tdata); end
        vec++; if (ireq_tkeep !== 8'h00) begin miss++; $display("FAIL reset tkeep: got %h expected 00", ireq_tkeep); end
        vec++; if (ireq_tuser !== 32'h0001_00FF) begin miss++; $display("FAIL reset tuser: got %h expected 000100ff", ireq_tuser); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int chk;
        int acc;
        do_reset();
        chk = exp_d.size();
        send_frame(34'h1000, 16'd64, 8, 7, 8'hFF, 1'b0, acc);
        drain();
        vec++; if (obs_d[chk] !== {8'h00, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'h3F, 2'b00, 34'h1000})
            begin miss++; $display("FAIL single header: got %h expected 0054_0_3F_1000 layout", obs_d[chk]); end
        vec++; if (obs_l[chk + 8] !== 1'b1 || obs_k[chk + 8] !== 8'hFF)
            begin miss++; $display("FAIL single last beat: got last %b keep %h expected 1 ff", obs_l[chk + 8], obs_k[chk + 8]); end
        vec++; if (obs_d.size() !== exp_d.size()) begin miss++; $display("FAIL single beat count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = chk; i < exp_d.size() && i < obs_d.size(); i++) begin
            vec++;
            if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
                miss++;
                $display("FAIL single beat %0d: got %h/%h/%b expected %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        vec++; if (obs_err !== exp_err) begin miss++; $display("FAIL single err count: got %0d expected %0d", obs_err, exp_err); end
    endtask

    task automatic test_multi_packet();
        int chk;
        int acc;
        int hdr[3];
        logic [7:0] sz[3];
        do_reset();
        chk = exp_d.size();
        send_frame(34'h0, 16'd600, 75, 74, 8'h0F, 1'b0, acc);
        drain();
        hdr = '{chk, chk + 33, chk + 66};
        sz  = '{8'hFF, 8'hFF, 8'h57};
        for (int p = 0; p < 3; p++) begin
            vec++;
            if (obs_d[hdr[p]][63:56] !== 8'(p) || obs_d[hdr[p]][43:36] !== sz[p] ||
                obs_d[hdr[p]][33:0] !== 34'(p * 256)) begin
                miss++;
                $display("FAIL multi header %0d: got tid %h size %h addr %h expected %h %h %h", p,
                         obs_d[hdr[p]][63:56], obs_d[hdr[p]][43:36], obs_d[hdr[p]][33:0], 8'(p), sz[p], 34'(p * 256));
            end
        end
        vec++; if (obs_k[chk + 77] !== 8'h0F || obs_l[chk + 77] !== 1'b1)
            begin miss++; $display("FAIL multi final beat: got keep %h last %b expected 0f 1", obs_k[chk + 77], obs_l[chk + 77]); end
        vec++; if (obs_d.size() !== exp_d.size()) begin miss++; $display("FAIL multi beat count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = chk; i < exp_d.size() && i < obs_d.size(); i++) begin
            vec++;
            if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
                miss++;
                $display("FAIL multi beat %0d: got %h/%h/%b expected %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        vec++; if (obs_err !== exp_err) begin miss++; $display("FAIL multi err count: got %0d expected %0d", obs_err, exp_err); end
    endtask

    task automatic test_tid_wrap();
        int chk;
        int acc;
        int err0;
        do_reset();
        chk  = exp_d.size();
        err0 = obs_err;
        for (int f = 0; f < 257; f++)
            send_frame(34'(f * 8), 16'd8, 1, 0, 8'($urandom), 1'b0, acc);
        drain();
        vec++; if (obs_d[chk + 2 * 255][63:56] !== 8'hFF) begin miss++; $display("FAIL wrap tid frame 256: got %h expected ff", obs_d[chk + 2 * 255][63:56]); end
        vec++; if (obs_d[chk + 2 * 256][63:56] !== 8'h00) begin miss++; $display("FAIL wrap tid frame 257: got %h expected 00", obs_d[chk + 2 * 256][63:56]); end
        vec++; if (obs_err !== err0) begin miss++; $display("FAIL wrap err pulses: got %0d expected 0", obs_err - err0); end
        vec++; if (obs_d.size() !== exp_d.size()) begin miss++; $display("FAIL wrap beat count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = chk; i < exp_d.size() && i < obs_d.size(); i++) begin
            vec++;
            if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
                miss++;
                $display("FAIL wrap beat %0d: got %h/%h/%b expected %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        int chk;
        int acc;
        int len;
        do_reset();
        chk = exp_d.size();
        stab_viol = 0;
        tready_mode = 1;
        send_frame(34'h3_0000_0000, 16'd600, 75, 74, 8'h0F, 1'b1, acc);
        send_frame(34'h2000, 16'd64, 8, 7, 8'hFF, 1'b0, acc);
        tready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 700);
            send_frame({2'($urandom), $urandom}, 16'(len), (len + 7) / 8, (len + 7) / 8 - 1,
                       8'($urandom_range(1, 255)), 1'b1, acc);
        end
        drain();
        tready_mode = 0;
        vec++; if (stab_viol !== 0) begin miss++; $display("FAIL stall stability: got %0d changes while stalled expected 0", stab_viol); end
        vec++; if (obs_d.size() !== exp_d.size()) begin miss++; $display("FAIL stall beat count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = chk; i < exp_d.size() && i < obs_d.size(); i++) begin
            vec++;
            if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
                miss++;
                $display("FAIL stall beat %0d: got %h/%h/%b expected %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        vec++; if (obs_err !== exp_err) begin miss++; $display("FAIL stall err count: got %0d expected %0d", obs_err, exp_err); end
    endtask

    task automatic test_errors();
        int chk;
        int acc;
        int err0;
        int n0;
        do_reset();
        chk  = exp_d.size();
        err0 = obs_err;
        send_frame(34'h1000, 16'd64, 5, 4, 8'h3C, 1'b0, acc);
        send_frame(34'h5000, 16'd8, 1, 0, 8'hFF, 1'b0, acc);
        drain();
        vec++; if (obs_l[chk + 5] !== 1'b1) begin miss++; $display("FAIL early last tlast: got %b expected 1", obs_l[chk + 5]); end
        vec++; if (obs_d[chk + 6][63:56] !== 8'h01) begin miss++; $display("FAIL early last next tid: got %h expected 01", obs_d[chk + 6][63:56]); end
        n0 = obs_d.size();
        send_frame(34'h0, 16'd0, 3, 2, 8'hFF, 1'b0, acc);
        drain();
        vec++; if (acc !== 3) begin miss++; $display("FAIL zero len consumed: got %0d beats expected 3", acc); end
        vec++; if (obs_d.size() !== n0) begin miss++; $display("FAIL zero len traffic: got %0d beats expected 0", obs_d.size() - n0); end
        send_frame(34'h8000, 16'd8, 2, 1, 8'hFF, 1'b0, acc);
        drain();
        vec++; if (acc !== 2) begin miss++; $display("FAIL overrun consumed: got %0d beats expected 2", acc); end
        vec++; if (obs_err - err0 !== 3) begin miss++; $display("FAIL error pulses: got %0d expected 3", obs_err - err0); end
        vec++; if (obs_d.size() !== exp_d.size()) begin miss++; $display("FAIL errors beat count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = chk; i < exp_d.size() && i < obs_d.size(); i++) begin
            vec++;
            if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
                miss++;
                $display("FAIL errors beat %0d: got %h/%h/%b expected %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
        vec++; if (obs_err !== exp_err) begin miss++; $display("FAIL errors err count: got %0d expected %0d", obs_err, exp_err); end
    endtask

    task automatic test_async_reset();
        int chk;
        int acc;
        do_reset();
        send_frame(34'h0, 16'd16, 2, 1, 8'hFF, 1'b0, acc);
        drain();
        // Start a frame and let it reach DATA, then reset between clock edges
        mon_en       = 1'b0;
        base_addr_in = 34'h40;
        length_in    = 16'd64;
        data_in      = {$urandom, $urandom};
        keep_in      = 8'hFF;
        last_in      = 1'b0;
        first_in     = 1'b1;
        nwr_req_in   = 1'b1;
        valid_in     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        first_in   = 1'b0;
        nwr_req_in = 1'b0;
        @(negedge clk);
        vec++; if (ireq_tvalid !== 1'b1 || ready_out !== 1'b1)
            begin miss++; $display("FAIL pre-reset data phase: got tvalid %b ready %b expected 1 1", ireq_tvalid, ready_out); end
        #2;
        rst = 1'b1;
        #1;
        vec++; if (ireq_tvalid !== 1'b0 || ready_out !== 1'b0 || busy_out !== 1'b0)
            begin miss++; $display("FAIL async reset: got tvalid %b ready %b busy %b expected 0 0 0", ireq_tvalid, ready_out, busy_out); end
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tid_m  = 8'h00;
        mon_en = 1'b1;
        chk    = exp_d.size();
        send_frame(34'h2000, 16'd16, 2, 1, 8'hFF, 1'b0, acc);
        drain();
        vec++; if (obs_d[chk][63:56] !== 8'h00) begin miss++; $display("FAIL post-reset tid: got %h expected 00", obs_d[chk][63:56]); end
        vec++; if (obs_d.size() !== exp_d.size()) begin miss++; $display("FAIL post-reset beat count: got %0d expected %0d", obs_d.size(), exp_d.size()); end
        for (int i = chk; i < exp_d.size() && i < obs_d.size(); i++) begin
            vec++;
            if (obs_d[i] !== exp_d[i] || obs_k[i] !== exp_k[i] || obs_l[i] !== exp_l[i]) begin
                miss++;
                $display("FAIL post-reset beat %0d: got %h/%h/%b expected %h/%h/%b", i, obs_d[i], obs_k[i], obs_l[i], exp_d[i], exp_k[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_multi_packet();
        test_tid_wrap();
        test_back_to_back_stall();
        test_errors();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/srio_nwr_packetizer.md
Name: srio_nwr_packetizer

Overview:
- Sits directly downstream of the UDP-to-SRIO CDC stage, in the clk_srio domain.
- Consumes the 64-bit payload stream and per-frame byte length, and segments each frame into SRIO NWRITE packets of at most MAX_BYTES.
- Each packet is a HELLO-format header beat followed by its payload beats, driven onto the SRIO core ireq AXI-Stream port.
- Destination address starts at base_addr_in and advances MAX_BYTES per packet; TID increments per packet.

Parameters:
- MAX_BYTES, 256: max payload bytes per NWRITE packet (power of 2, multiple of 8, ≤256).
- SRC_ID, 16'h0001: source device ID placed in ireq_tuser[31:16].
- DEST_ID, 16'h00FF: destination device ID placed in ireq_tuser[15:0].
- PRIO, 2'b01: SRIO priority field.

Ports:
- clk_srio  in  1  SRIO-domain clock.
- reset_srio  in  1  asynchronous, active-high reset.
- base_addr_in  in  34  start address, sampled at frame start.
- nwr_req_in  in  1  frame start strobe, coincident with first beat.
- length_in  in  16  frame byte count, sampled at frame start.
- data_in  in  64  payload beat.
- valid_in  in  1  payload beat valid.
- first_in  in  1  first beat of frame.
- keep_in  in  8  byte enables, honoured on the final beat only.
- last_in  in  1  last beat of frame.
- ready_out  out  1  beat accepted when valid_in && ready_out.
- ireq_tdata  out  64  header or payload.
- ireq_tvalid  out  1  ireq beat valid.
- ireq_tkeep  out  8  byte enables.
- ireq_tlast  out  1  last beat of packet.
- ireq_tuser  out  32  {SRC_ID, DEST_ID}.
- ireq_tready  in  1  SRIO core ready.
- busy_out  out  1  high when not in IDLE.
- err_out  out  1  one-cycle pulse on framing/length error.

Behaviour:
- Reset: state IDLE; ready_out, ireq_tvalid, ireq_tlast, busy_out, err_out = 0; ireq_tdata, ireq_tkeep = 0; TID = 0.
- Reset mid-packet aborts immediately; there is no recovery of the partial packet.
- Upstream must follow standard valid/ready: data held while ready_out = 0.
- FSM states: IDLE, HEADER, DATA, DROP.
- IDLE:
  - ready_out = 0.
  - On valid_in && (first_in || nwr_req_in): latch rem = length_in and addr = base_addr_in. The beat is not consumed.
  - If length_in == 0: pulse err_out, go to DROP.
  - Otherwise: seg = min(rem, MAX_BYTES), seg_beats = ceil(seg/8), go to HEADER.
- HEADER:
  - ireq_tvalid = 1, ireq_tkeep = 8'hFF, ireq_tlast = 0, ready_out = 0.
  - ireq_tdata fields: [63:56] TID, [55:52] FTYPE = 4'h5, [51:48] TTYPE = 4'h4, [47] 0, [46:45] PRIO, [44] CRF = 0, [43:36] seg−1, [35:34] 0, [33:0] addr.
  - On ireq_tready: go to DATA, beat_cnt = 0.
- DATA:
  - Combinational pass-through: ireq_tdata = data_in, ireq_tvalid = valid_in, ready_out = ireq_tready.
  - ireq_tkeep = 8'hFF except on the final beat of the frame, where it equals keep_in.
  - ireq_tlast = (beat_cnt == seg_beats−1).
  - beat_cnt increments on each accepted beat.
  - On the accepted tlast beat: rem −= seg, addr += MAX_BYTES (34-bit wrap), TID += 1 (wraps 255→0).
  - If rem != 0 after the update: go to HEADER. Otherwise go to IDLE.
- Error cases:
  - last_in accepted before the frame's final counted beat: force ireq_tlast = 1 on that beat, pulse err_out, go to IDLE, TID += 1.
  - Final counted beat accepted without last_in: pulse err_out, go to DROP.
- DROP: ireq_tvalid = 0, ready_out = 1. Discard beats until last_in is accepted, then go to IDLE.
- Latency: header appears on ireq the cycle after frame start is seen in IDLE. No bubbles otherwise beyond one header beat per packet.
- ireq_tuser is constant.
- ireq outputs are held stable while ireq_tvalid && !ireq_tready.

Test Plan:
- length 64, base 0x1000, 8 beats, ireq_tready = 1 → header TID 0, SIZE 0x3F, addr 0x1000; 8 data beats; tlast on beat 8; tkeep = keep_in = 0xFF.
- length 600, base 0x0 → 3 packets with SIZE 0xFF/0xFF/0x57, addr 0x000/0x100/0x200, TID 0/1/2, beats 32/32/11; final tkeep = keep_in (0x0F).
- 257 consecutive 8-byte frames → TID wraps 0xFF→0x00 on frame 257; no err_out.
- ireq_tready toggled 1010… during header and data → no beat lost or duplicated; outputs stable while stalled; ready_out follows ireq_tready in DATA.
- length 64 but last_in on beat 5 → tlast on beat 5, err_out pulse, next frame TID = 1. Second case: length 0 with 3 beats → no ireq traffic, err_out pulse, all 3 beats consumed.
- Async reset asserted mid-DATA → ireq_tvalid and ready_out drop without waiting for a clock edge; after release, state is IDLE and the next header carries TID 0.
